// File: rtl/bcd_pkg.sv
// Shared FSM encoding and default sizing for the serial BCD-to-binary converter.
// Defaults size the result for four BCD digits (9999 needs 14 bits).
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEF_DIGITS = 4;
  localparam int DEF_BIN_W  = 14;

endpackage

// File: rtl/bcd_digit_adj.sv
// One reverse double-dabble digit correction: a shifted nibble >= 8 carried in half of ten,
// so subtracting 3 turns the +8 into the correct +5. Purely combinational.
module bcd_digit_adj (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd8) ? (nib_i - 4'd3) : nib_i;

endmodule

// File: rtl/bcd_to_bin_serial.sv
// Serial packed-BCD to binary converter (reverse double-dabble), one bit per clock.
// Valid input: BIN_W steps then a one-cycle DONE; an invalid nibble goes straight to DONE with err.
module bcd_to_bin_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BIN_W  = DEF_BIN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BIN_W-1:0]   bin_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIN_W-1:0]   bin_out_q;
  logic               err_q;

  logic [BCD_W-1:0]   bcd_shift;
  logic [BCD_W-1:0]   bcd_d;
  logic [BIN_W-1:0]   bin_d;
  logic               in_bad;

  // {bcd, bin} shifted right by one; the BCD LSB falls into the binary MSB.
  assign {bcd_shift, bin_d} = {1'b0, bcd_q, bin_q[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .nib_i (bcd_shift[4*g +: 4]),
      .nib_o (bcd_d[4*g +: 4])
    );
  end

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            bcd_q <= bcd_in;
            bin_q <= '0;
            cnt_q <= '0;
            err_q <= in_bad;
            if (in_bad) begin
              bin_out_q <= '0;
              state_q   <= ST_DONE;
            end else begin
              state_q   <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BIN_W - 1)) begin
            bin_out_q <= bin_d;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign bin_out = bin_out_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_serial.sv
// Directed bench for bcd_to_bin_serial: latency, results, error path, ignored start, reset abort.
module tb_bcd_to_bin_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic [13:0] bin_out;
  logic        err;

  int checks = 0;
  int errors = 0;

  bcd_to_bin_serial #(.DIGITS(4), .BIN_W(14)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Samples #1 after each edge until done; n counts edges after the accept edge.
  // At sample poke_at, start is pulsed and bcd_in corrupted for one cycle.
  task automatic wait_done(input int poke_at, input logic [13:0] mid_bin,
                           output int n, output int busy_cnt);
    n = 0;
    busy_cnt = 0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      if (n == poke_at) begin
        check("mid_bin_hold", 32'(bin_out), 32'(mid_bin));
        start  = 1'b1;
        bcd_in = 16'h9999;
      end else if (n == poke_at + 1) begin
        start  = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    if (busy) busy_cnt++;
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic convert(input string tag, input logic [15:0] bcd, input logic [13:0] exp_bin,
                         input logic exp_err, input int exp_lat,
                         input int poke_at, input logic [13:0] mid_bin);
    int n, bc;
    bcd_in = bcd;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    check({tag, "_busy_acc"}, 32'(busy), 32'd1);
    wait_done(poke_at, mid_bin, n, bc);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_busy_cnt"}, 32'(bc), 32'(exp_lat + 1));
    check({tag, "_bin"}, 32'(bin_out), 32'(exp_bin));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    @(posedge clk); #1;
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_bin_hold"}, 32'(bin_out), 32'(exp_bin));
  endtask

  initial begin
    int n, bc, done_cnt;
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = 16'h0000;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err",  32'(err),  32'd0);
    check("rst_bin",  32'(bin_out), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    convert("c2359", 16'h2359, 14'd2359, 1'b0, 14, -10, 14'd0);
    convert("c12A4", 16'h12A4, 14'd0,    1'b1, 0,  -10, 14'd0);
    convert("c9999", 16'h9999, 14'd9999, 1'b0, 14, -10, 14'd0);
    convert("c0059", 16'h0059, 14'd59,   1'b0, 14, 5,   14'd9999);
    convert("c0000", 16'h0000, 14'd0,    1'b0, 14, -10, 14'd0);

    // Reset in the middle of a conversion: outputs clear at once, no done afterwards.
    bcd_in = 16'h0123;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    check("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bin",  32'(bin_out), 32'd0);
    check("abort_err",  32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    done_cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    convert("c0100", 16'h0100, 14'd100, 1'b0, 14, -10, 14'd0);

    // Start held high: second request taken in the first IDLE cycle after DONE.
    bcd_in = 16'h0001;
    start  = 1'b1;
    @(posedge clk); #1;
    wait_done(-10, 14'd0, n, bc);
    check("held1_lat", 32'(n), 32'd14);
    check("held1_bin", 32'(bin_out), 32'd1);
    bcd_in = 16'h0002;
    @(posedge clk); #1;
    check("held_idle_gap", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("held2_accept", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(-10, 14'd0, n, bc);
    check("held2_lat", 32'(n), 32'd14);
    check("held2_bin", 32'(bin_out), 32'd2);
    check("held2_err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_serial.md
BCD_TO_BIN_SERIAL -- requirements
Module: bcd_to_bin_serial

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of packed BCD digits at the input.
REQ-002 SHALL have parameter BIN_W, default 14: result width; BIN_W >= ceil(log2(10^DIGITS)).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: conversion request, sampled on the rising edge.
REQ-006 SHALL have port bcd_in, input, 4*DIGITS bits: packed BCD, most significant digit in the top nibble.
REQ-007 SHALL have port busy, output, 1 bit: high whenever the block is not IDLE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port bin_out, output, BIN_W bits: binary result.
REQ-010 SHALL have port err, output, 1 bit: set when the accepted input held a nibble > 9.

Function
REQ-011 SHALL implement the states IDLE, SHIFT and DONE; busy = (state != IDLE).
REQ-012 SHALL accept start only in IDLE; at the accepting edge it latches bcd_in into a working register, clears the binary shift register and the step counter, and clears err.
REQ-013 SHALL, if any latched nibble is > 9, go IDLE->DONE at the accepting edge with err=1 and bin_out=0.
REQ-014 SHALL, for valid input, go IDLE->SHIFT and perform exactly BIN_W steps, one per clock (reverse double-dabble).
REQ-015 SHALL define each step as: shift {bcd_work, bin_work} right by 1; then subtract 3 from every BCD nibble whose shifted value is >= 8.
REQ-016 SHALL, on the BIN_W-th step edge, load bin_out from the shift register and enter DONE.
REQ-017 SHALL hold done=1 for exactly the one cycle spent in DONE; DONE->IDLE unconditionally on the next edge.
REQ-018 SHALL give a latency for valid input of BIN_W+1 edges from the accepting edge to the edge that leaves DONE; done is high during the cycle after edge BIN_W.
REQ-019 SHALL ignore start in SHIFT and in DONE, and SHALL ignore bcd_in changes after acceptance.
REQ-020 SHALL hold bin_out and err stable from a completion until the next completion.
REQ-021 SHALL accept a new conversion in the first IDLE cycle after DONE when start is held high.

Reset
REQ-022 SHALL, while rst=1, immediately force state=IDLE, busy=0, done=0, err=0, bin_out=0, and clear all working registers and the counter.
REQ-023 SHALL, when rst asserts mid-conversion, abort the conversion with no done pulse; the first edge after release treats start normally.

Structure
REQ-024 SHALL place the state enum and the default constants DIGITS=4 and BIN_W=14 in a shared package, bcd_pkg.
REQ-025 SHALL implement the per-nibble ">=8 then -3" correction in one sub-module, bcd_digit_adj (4-bit in, 4-bit out, combinational), instantiated DIGITS times.
REQ-026 SHALL keep all other logic (FSM, counter, shift registers) in bcd_to_bin_serial.

Verification
REQ-027 SHALL check: bcd_in=16'h2359, start pulse -> busy for 15 cycles, done pulse 14 cycles after accept, bin_out=14'd2359 (0x0937), err=0.
REQ-028 SHALL check: bcd_in=16'h9999 -> bin_out=14'd9999 (0x270F); bcd_in=16'h0000 -> bin_out=0, same latency.
REQ-029 SHALL check: bcd_in=16'h12A4 -> err=1, bin_out=0, done on the cycle after accept, busy for 1 cycle.
REQ-030 SHALL check: start pulsed again and bcd_in changed at step 5 of a 16'h0059 conversion -> ignored; result is 59.
REQ-031 SHALL check: rst asserted at step 7 -> all outputs 0 immediately, no done pulse; the next conversion of 16'h0100 gives 100.
REQ-032 SHALL check: start held high across two conversions (16'h0001 then 16'h0002) -> the second is accepted on the cycle after done, with results 1 and 2.
